cv32e40p_apu_shared_arbiter: RTL and testbench
==============================================

// Module: cv32e40p_apu_shared_arbiter
// PURPOSE
// Shares one fpnew-style APU (tagged req/gnt request, valid-only response) among NB_CH cv32e40p APU master ports.
// Round-robin arbitration tags each accepted request with its channel index.
// Responses are routed back by tag. Per-channel credit counters bound in-flight ops to MAX_OUTST.
// Sits between the cluster cores and a single FPU instance; the FPU is driven with out_ready=1.
// PARAMETERS
// NB_CH      4   number of core channels (>=2)
// NARGS      3   operands per request, DATA_W bits each
// DATA_W     32  operand/result width
// WOP        6   op field width ({vec, op_mod, op})
// NDSFLAGS   15  downstream flags width ({int_fmt, src_fmt, dst_fmt, rnd_mode})
// NUSFLAGS   5   upstream status flags width
// MAX_OUTST  2   max in-flight ops per channel (>=1); CNT_W=$clog2(MAX_OUTST+1)
// ID_W       $clog2(NB_CH)  tag width (localparam)
// PORTS
// clk_i          in   1                    clock
// rst_i          in   1                    asynchronous reset, active-high
// ch_req_i       in   NB_CH                per-channel request
// ch_gnt_o       out  NB_CH                per-channel grant
// ch_operands_i  in   NB_CH*NARGS*DATA_W   per-channel operands
// ch_op_i        in   NB_CH*WOP            per-channel op
// ch_flags_i     in   NB_CH*NDSFLAGS       per-channel flags
// ch_rvalid_o    out  NB_CH                per-channel response valid
// ch_rdata_o     out  DATA_W               result, broadcast to all channels
// ch_rflags_o    out  NUSFLAGS             status flags, broadcast
// ch_busy_o      out  NB_CH                channel has >=1 op in flight
// fpu_req_o      out  1                    request to FPU (in_valid)
// fpu_gnt_i      in   1                    FPU accept (in_ready)
// fpu_operands_o out  NARGS*DATA_W         muxed operands
// fpu_op_o       out  WOP                  muxed op
// fpu_flags_o    out  NDSFLAGS             muxed flags
// fpu_tag_o      out  ID_W                 winning channel index
// fpu_rvalid_i   in   1                    FPU out_valid
// fpu_rdata_i    in   DATA_W               FPU result
// fpu_rflags_i   in   NUSFLAGS             FPU status
// fpu_rtag_i     in   ID_W                 tag returned with result
// err_o          out  1                    sticky: response with tag of a channel having 0 credits used
// BEHAVIOUR
// - State: rr_ptr[ID_W], cnt[NB_CH][CNT_W], err. Reset (async, rst_i=1): rr_ptr=0, all cnt=0, err=0.
//   Consequently ch_busy_o=0 and err_o=0. Combinational outputs follow inputs with zeroed state.
// - Eligible(i) = ch_req_i[i] && cnt[i] < MAX_OUTST.
// - Winner: first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NB_CH.
//   fpu_req_o = |eligible. fpu_* payload and fpu_tag_o = winner's; payload is 0 when no eligible channel.
// - ch_gnt_o[i] = fpu_req_o && fpu_gnt_i && winner==i (one-hot or zero). Same-cycle, combinational, no added latency.
// - Channels hold req and payload until granted. A non-granted channel is never dropped.
// - On accept (fpu_req_o && fpu_gnt_i): rr_ptr <= (winner+1) mod NB_CH. Otherwise rr_ptr holds.
//   An ungranted but presented winner is not skipped.
// - Response: ch_rvalid_o[i] = fpu_rvalid_i && fpu_rtag_i==i && cnt[i]!=0. Rdata/rflags pass through combinationally (0-cycle).
//   fpu_rtag_i >= NB_CH or cnt==0 -> response dropped, err <= 1 (sticky until reset).
// - cnt[i]: +1 on accept of i, -1 on valid response to i, unchanged when both occur in the same cycle. Never wraps.
//   A channel at MAX_OUTST is ineligible even if its response retires that cycle; it becomes eligible next cycle.
// - Backpressure: FPU out_ready is tied 1 externally. The block never stalls responses.
// - Reset mid-operation clears credits. The FPU and cores must share rst_i; no stale responses are tolerated.
// - Ordering: per-channel results arrive in FPU order. The block does not reorder.
// TESTING
// 1. Reset: rst_i=1 with ch_req_i=4'hF -> during reset ch_busy_o=0, err_o=0, fpu_tag_o=0.
//    First accept after release grants ch0, then ch1, ch2, ch3.
// 2. All 4 request, fpu_gnt_i toggled 1,0,1,1 -> grants ch0, (hold ch1), ch1, ch2. rr_ptr=3 afterwards.
// 3. MAX_OUTST=2: ch2 alone issues 3 ops, no responses -> 2 grants, then fpu_req_o=0 and ch_busy_o[2]=1.
//    Response tag=2 -> next cycle 3rd op granted.
// 4. Same-cycle grant to ch1 and response tag=1 with cnt[1]=1 -> cnt[1] stays 1, ch_rvalid_o=4'b0010.
//    rdata 0x3F800000 seen on ch_rdata_o.
// 5. fpu_rvalid_i with tag=3 while cnt[3]=0 -> ch_rvalid_o=0, err_o=1 next cycle, stays 1 until rst_i.
// 6. Reset asserted with cnt={1,2,0,1} mid-stream -> all cnt=0 and ch_busy_o=0 immediately (async).

Source files
------------

// File: rtl/cv32e40p_apu_shared_arbiter.sv
// Shared APU arbiter: round-robin access to one fpnew-style FPU for NB_CH
// cv32e40p APU ports. Requests carry the channel index as a tag, and responses
// are routed back by that tag. Per-channel credits bound the in-flight ops.

// Per-channel credit counter. It counts ops that were accepted by the FPU but
// have not been retired yet.
module cv32e40p_apu_credit_cnt #(
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc,    // op accepted for this channel
    input  logic dec,    // valid response retired for this channel
    output logic avail,  // credit left for another op
    output logic busy    // at least one op in flight
);
    logic [CNT_W-1:0] cnt;

    // The arbiter only increments when avail=1 and only decrements when
    // busy=1, so the count never wraps. Inc and dec together cancel out.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt <= '0;
        else if (inc && !dec)
            cnt <= cnt + 1'b1;
        else if (dec && !inc)
            cnt <= cnt - 1'b1;
    end

    assign avail = (cnt < CNT_W'(MAX_OUTST));
    assign busy  = (cnt != '0);
endmodule

module cv32e40p_apu_shared_arbiter #(
    parameter int NB_CH     = 4,
    parameter int NARGS     = 3,
    parameter int DATA_W    = 32,
    parameter int WOP       = 6,
    parameter int NDSFLAGS  = 15,
    parameter int NUSFLAGS  = 5,
    parameter int MAX_OUTST = 2,
    localparam int ID_W     = $clog2(NB_CH),
    localparam int CNT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NB_CH-1:0]                       ch_req_i,
    output logic [NB_CH-1:0]                       ch_gnt_o,
    input  logic [NB_CH-1:0][NARGS*DATA_W-1:0]     ch_operands_i,
    input  logic [NB_CH-1:0][WOP-1:0]              ch_op_i,
    input  logic [NB_CH-1:0][NDSFLAGS-1:0]         ch_flags_i,
    output logic [NB_CH-1:0]                       ch_rvalid_o,
    output logic [DATA_W-1:0]                      ch_rdata_o,
    output logic [NUSFLAGS-1:0]                    ch_rflags_o,
    output logic [NB_CH-1:0]                       ch_busy_o,
    output logic                                   fpu_req_o,
    input  logic                                   fpu_gnt_i,
    output logic [NARGS*DATA_W-1:0]                fpu_operands_o,
    output logic [WOP-1:0]                         fpu_op_o,
    output logic [NDSFLAGS-1:0]                    fpu_flags_o,
    output logic [ID_W-1:0]                        fpu_tag_o,
    input  logic                                   fpu_rvalid_i,
    input  logic [DATA_W-1:0]                      fpu_rdata_i,
    input  logic [NUSFLAGS-1:0]                    fpu_rflags_i,
    input  logic [ID_W-1:0]                        fpu_rtag_i,
    output logic                                   err_o
);
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  winner;
    logic             found;
    logic             accept;
    logic             err;
    logic [NB_CH-1:0] avail;
    logic [NB_CH-1:0] elig;

    // Per-channel credit counters, grant decode and response routing.
    for (genvar g = 0; g < NB_CH; g++) begin : g_ch
        cv32e40p_apu_credit_cnt #(
            .MAX_OUTST (MAX_OUTST),
            .CNT_W     (CNT_W)
        ) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc   (ch_gnt_o[g]),
            .dec   (ch_rvalid_o[g]),
            .avail (avail[g]),
            .busy  (ch_busy_o[g])
        );

        assign ch_gnt_o[g]    = accept && (winner == ID_W'(g));
        // A channel with zero credits used has nothing to retire, so a
        // response tagged for it is stray and gets dropped.
        assign ch_rvalid_o[g] = fpu_rvalid_i && (fpu_rtag_i == ID_W'(g)) && ch_busy_o[g];
    end

    // A channel at its credit limit stays ineligible for the whole cycle, even
    // when a response retires one of its ops in that same cycle.
    assign elig   = ch_req_i & avail;
    assign accept = fpu_req_o && fpu_gnt_i;

    // Round-robin pick of the first eligible channel, starting at rr_ptr.
    // The payload of the winning channel is muxed out, and is zero when idle.
    always_comb begin
        int idx;
        idx            = 0;
        found          = 1'b0;
        winner         = '0;
        fpu_operands_o = '0;
        fpu_op_o       = '0;
        fpu_flags_o    = '0;
        for (int k = 0; k < NB_CH; k++) begin
            idx = (int'(rr_ptr) + k) % NB_CH;
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
        if (found) begin
            fpu_operands_o = ch_operands_i[winner];
            fpu_op_o       = ch_op_i[winner];
            fpu_flags_o    = ch_flags_i[winner];
        end
    end

    assign fpu_req_o   = found;
    assign fpu_tag_o   = winner;
    assign ch_rdata_o  = fpu_rdata_i;
    assign ch_rflags_o = fpu_rflags_i;
    assign err_o       = err;

    // Move the pointer past the winner only when the FPU accepts the request.
    // A stalled winner keeps priority until it gets its grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= (winner == ID_W'(NB_CH - 1)) ? '0 : winner + 1'b1;
    end

    // Sticky error flag. It is set by any response that no channel accepts:
    // either the tag is out of range or the tagged channel has nothing in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            err <= 1'b0;
        else if (fpu_rvalid_i && !(|ch_rvalid_o))
            err <= 1'b1;
    end
endmodule

// File: tb/tb_cv32e40p_apu_shared_arbiter.sv
// Directed, table-driven bench for cv32e40p_apu_shared_arbiter.
module tb_cv32e40p_apu_shared_arbiter;
    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [3:0]           ch_req_i;
    logic [3:0]           ch_gnt_o;
    logic [3:0][95:0]     ch_operands_i;
    logic [3:0][5:0]      ch_op_i;
    logic [3:0][14:0]     ch_flags_i;
    logic [3:0]           ch_rvalid_o;
    logic [31:0]          ch_rdata_o;
    logic [4:0]           ch_rflags_o;
    logic [3:0]           ch_busy_o;
    logic                 fpu_req_o;
    logic                 fpu_gnt_i;
    logic [95:0]          fpu_operands_o;
    logic [5:0]           fpu_op_o;
    logic [14:0]          fpu_flags_o;
    logic [1:0]           fpu_tag_o;
    logic                 fpu_rvalid_i;
    logic [31:0]          fpu_rdata_i;
    logic [4:0]           fpu_rflags_i;
    logic [1:0]           fpu_rtag_i;
    logic                 err_o;

    int n_chk  = 0;
    int n_fail = 0;

    cv32e40p_apu_shared_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ch_req_i(ch_req_i), .ch_gnt_o(ch_gnt_o),
        .ch_operands_i(ch_operands_i), .ch_op_i(ch_op_i), .ch_flags_i(ch_flags_i),
        .ch_rvalid_o(ch_rvalid_o), .ch_rdata_o(ch_rdata_o), .ch_rflags_o(ch_rflags_o),
        .ch_busy_o(ch_busy_o),
        .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i),
        .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_flags_o(fpu_flags_o),
        .fpu_tag_o(fpu_tag_o),
        .fpu_rvalid_i(fpu_rvalid_i), .fpu_rdata_i(fpu_rdata_i),
        .fpu_rflags_i(fpu_rflags_i), .fpu_rtag_i(fpu_rtag_i),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;     // pulse reset before applying this vector
        logic [3:0]  req;
        logic        gnt;
        logic        rvld;
        logic [1:0]  rtag;
        logic [31:0] rdata;
        logic [3:0]  e_gnt;
        logic        e_req;
        logic [1:0]  e_tag;
        logic [3:0]  e_rvld;
        logic [3:0]  e_busy;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [3:0] req, logic gnt, logic rvld,
                                logic [1:0] rtag, logic [31:0] rdata,
                                logic [3:0] e_gnt, logic e_req, logic [1:0] e_tag,
                                logic [3:0] e_rvld, logic [3:0] e_busy, logic e_err);
        vec_t v;
        v.rst = rst; v.req = req; v.gnt = gnt; v.rvld = rvld; v.rtag = rtag; v.rdata = rdata;
        v.e_gnt = e_gnt; v.e_req = e_req; v.e_tag = e_tag; v.e_rvld = e_rvld;
        v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    function automatic logic [95:0] ops_of(int i);
        return {32'hA000_0000 + 32'(i*16 + 2), 32'hA000_0000 + 32'(i*16 + 1),
                32'hA000_0000 + 32'(i*16)};
    endfunction
    function automatic logic [5:0]  op_of(int i);    return 6'(i + 1);          endfunction
    function automatic logic [14:0] flags_of(int i); return 15'h100 + 15'(i);  endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(vec_t v);
        ch_req_i     = v.req;
        fpu_gnt_i    = v.gnt;
        fpu_rvalid_i = v.rvld;
        fpu_rtag_i   = v.rtag;
        fpu_rdata_i  = v.rdata;
        fpu_rflags_i = v.rdata[4:0];
    endtask

    task automatic check_vec(int n, vec_t v);
        string s;
        s = $sformatf("v%0d", n);
        chk({s, ".ch_gnt"},    ch_gnt_o,    v.e_gnt);
        chk({s, ".fpu_req"},   fpu_req_o,   v.e_req);
        chk({s, ".fpu_tag"},   fpu_tag_o,   v.e_tag);
        chk({s, ".ch_rvalid"}, ch_rvalid_o, v.e_rvld);
        chk({s, ".ch_busy"},   ch_busy_o,   v.e_busy);
        chk({s, ".err"},       err_o,       v.e_err);
        chk({s, ".rdata"},     ch_rdata_o,  v.rdata);
        chk({s, ".operands"},  fpu_operands_o, v.e_req ? ops_of(int'(v.e_tag)) : 96'd0);
        chk({s, ".op"},        fpu_op_o,       v.e_req ? op_of(int'(v.e_tag)) : 6'd0);
        chk({s, ".flags"},     fpu_flags_o,    v.e_req ? flags_of(int'(v.e_tag)) : 15'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ch_operands_i[i] = ops_of(i);
            ch_op_i[i]       = op_of(i);
            ch_flags_i[i]    = flags_of(i);
        end
        rst_i = 1'b1;
        ch_req_i = 4'hF; fpu_gnt_i = 1'b1; fpu_rvalid_i = 1'b0;
        fpu_rtag_i = '0; fpu_rdata_i = '0; fpu_rflags_i = '0;

        // Held in reset with every channel requesting.
        #3;
        chk("rst.busy",    ch_busy_o, 4'h0);
        chk("rst.err",     err_o,     1'b0);
        chk("rst.fpu_tag", fpu_tag_o, 2'd0);
        chk("rst.fpu_req", fpu_req_o, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b0;

        //            rst  req    gnt rv  rtag  rdata           e_gnt  ereq etag erv    ebusy  eerr
        // Rotation after reset: ch0, ch1, ch2, ch3.
        tbl.push_back(mk(0, 4'hF, 1, 0, 2'd0, 32'h0,          4'h1, 1, 2'd0, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 4'hF, 1, 0, 2'd0, 32'h0,          4'h2, 1, 2'd1, 4'h0, 4'h1, 0));
        tbl.push_back(mk(0, 4'hF, 1, 0, 2'd0, 32'h0,          4'h4, 1, 2'd2, 4'h0, 4'h3, 0));
        tbl.push_back(mk(0, 4'hF, 1, 0, 2'd0, 32'h0,          4'h8, 1, 2'd3, 4'h0, 4'h7, 0));
        // FPU grant pattern 1,0,1,1: ch1 is held and not skipped, rr_ptr ends at 3.
        tbl.push_back(mk(1, 4'hF, 1, 0, 2'd0, 32'h0,          4'h1, 1, 2'd0, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 0, 2'd0, 32'h0,          4'h0, 1, 2'd1, 4'h0, 4'h1, 0));
        tbl.push_back(mk(0, 4'hF, 1, 0, 2'd0, 32'h0,          4'h2, 1, 2'd1, 4'h0, 4'h1, 0));
        tbl.push_back(mk(0, 4'hF, 1, 0, 2'd0, 32'h0,          4'h4, 1, 2'd2, 4'h0, 4'h3, 0));
        tbl.push_back(mk(0, 4'hF, 0, 0, 2'd0, 32'h0,          4'h0, 1, 2'd3, 4'h0, 4'h7, 0));
        // Credit limit: ch2 alone. The third op waits for a response, and the
        // retiring cycle itself still does not grant.
        tbl.push_back(mk(1, 4'h4, 1, 0, 2'd0, 32'h0,          4'h4, 1, 2'd2, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 4'h4, 1, 0, 2'd0, 32'h0,          4'h4, 1, 2'd2, 4'h0, 4'h4, 0));
        tbl.push_back(mk(0, 4'h4, 1, 0, 2'd0, 32'h0,          4'h0, 0, 2'd0, 4'h0, 4'h4, 0));
        tbl.push_back(mk(0, 4'h4, 1, 1, 2'd2, 32'h4049_0FDB,  4'h0, 0, 2'd0, 4'h4, 4'h4, 0));
        tbl.push_back(mk(0, 4'h4, 1, 0, 2'd0, 32'h0,          4'h4, 1, 2'd2, 4'h0, 4'h4, 0));
        // Grant and response to ch1 in the same cycle: the count stays at 1.
        tbl.push_back(mk(1, 4'h2, 1, 0, 2'd0, 32'h0,          4'h2, 1, 2'd1, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 4'h2, 1, 1, 2'd1, 32'h3F80_0000,  4'h2, 1, 2'd1, 4'h2, 4'h2, 0));
        tbl.push_back(mk(0, 4'h0, 0, 1, 2'd1, 32'h4000_0000,  4'h0, 0, 2'd0, 4'h2, 4'h2, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 2'd0, 32'h0,          4'h0, 0, 2'd0, 4'h0, 4'h0, 0));
        // Stray response to idle ch3: dropped, err set next cycle and sticky.
        tbl.push_back(mk(0, 4'h0, 0, 1, 2'd3, 32'h1234_5678,  4'h0, 0, 2'd0, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 2'd0, 32'h0,          4'h0, 0, 2'd0, 4'h0, 4'h0, 1));
        tbl.push_back(mk(0, 4'h0, 1, 0, 2'd0, 32'h0,          4'h0, 0, 2'd0, 4'h0, 4'h0, 1));

        foreach (tbl[n]) begin
            if (tbl[n].rst) begin
                rst_i = 1'b1;
                #1;
                rst_i = 1'b0;
            end
            apply(tbl[n]);
            #2;
            check_vec(n, tbl[n]);
            @(negedge clk_i);
        end

        // Mid-stream async reset: build per-channel counts 1,0,2,1 (ch0..ch3)
        // while err is still set, then assert rst_i with the clock low.
        fpu_gnt_i = 1'b1; fpu_rvalid_i = 1'b0;
        ch_req_i = 4'b0001; @(negedge clk_i);
        ch_req_i = 4'b0100; @(negedge clk_i);
        ch_req_i = 4'b0100; @(negedge clk_i);
        ch_req_i = 4'b1000; @(negedge clk_i);
        ch_req_i = 4'b0000;
        #1;
        chk("mid.busy_before", ch_busy_o, 4'b1101);
        chk("mid.err_before",  err_o,     1'b1);
        ch_req_i = 4'b0100;
        #1;
        chk("mid.ch2_full", fpu_req_o, 1'b0);
        rst_i = 1'b1;
        #1;
        chk("mid.busy_async", ch_busy_o, 4'b0000);
        chk("mid.err_async",  err_o,     1'b0);
        chk("mid.req_freed",  fpu_req_o, 1'b1);
        chk("mid.tag",        fpu_tag_o, 2'd2);
        @(negedge clk_i);
        rst_i = 1'b0;
        ch_req_i = 4'hF;
        #1;
        chk("post.tag", fpu_tag_o, 2'd0);
        chk("post.gnt", ch_gnt_o,  4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
